// File: rtl/button_led_wb.sv
// Wishbone slave exposing three debounced buttons (with sticky rise flags and
// a level interrupt) and an 8-bit LED port with a debounce-mirror mode.
module button_led_wb #(
    parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
    parameter int          DB_CYCLES = 16
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        wbs_stb_i,
    input  logic        wbs_cyc_i,
    input  logic        wbs_we_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic [31:0] wbs_adr_i,
    input  logic [31:0] wbs_dat_i,
    output logic        wbs_ack_o,
    output logic [31:0] wbs_dat_o,
    input  logic [2:0]  btn_i,
    output logic [7:0]  led_o,
    output logic [7:0]  led_oeb_o,
    output logic        irq_o
);

    localparam logic [15:0] DB_LAST = 16'(DB_CYCLES - 1);

    logic [2:0]  sync1_reg, sync2_reg;
    logic [2:0]  db;
    logic [2:0]  db_rise;
    logic [2:0]  pend_reg;
    logic [2:0]  irq_en_reg;
    logic [7:0]  led_reg, oeb_reg, led_out_reg;
    logic        mode_reg, ack_reg, irq_reg;
    logic [31:0] dat_reg;
    logic        wb_req, reg_hit, wr_en;
    logic [1:0]  reg_off;
    logic [31:0] rdata;
    logic [2:0]  evt_clr;
    logic        unused_bits;

    // Each button debounces independently: db only flips after DB_CYCLES
    // consecutive clocks of disagreement with the synchronized input.
    for (genvar gi = 0; gi < 3; gi++) begin : g_db
        logic [15:0] cnt_reg;
        logic        db_bit_reg;

        always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
            if (wb_rst_i) begin
                cnt_reg    <= 16'd0;
                db_bit_reg <= 1'b0;
            end else if (sync2_reg[gi] == db_bit_reg) begin
                cnt_reg <= 16'd0;
            end else if (cnt_reg == DB_LAST) begin
                cnt_reg    <= 16'd0;
                db_bit_reg <= ~db_bit_reg;
            end else begin
                cnt_reg <= cnt_reg + 16'd1;
            end
        end

        assign db[gi]      = db_bit_reg;
        assign db_rise[gi] = (sync2_reg[gi] != db_bit_reg) && (cnt_reg == DB_LAST) && !db_bit_reg;
    end

    // The ack is registered straight from the request, so a pending ack never
    // spans an edge where cyc could drop first.
    assign wb_req  = wbs_stb_i & wbs_cyc_i & ~ack_reg;
    assign reg_hit = (wbs_adr_i[31:4] == BASE_ADDR[31:4]);
    assign reg_off = wbs_adr_i[3:2];
    assign wr_en   = wb_req & wbs_we_i & reg_hit;

    always_comb begin
        rdata = '0;
        if (reg_hit) begin
            case (reg_off)
                2'd0: rdata[7:0] = led_reg;
                2'd1: begin
                    rdata[0]    = mode_reg;
                    rdata[6:4]  = irq_en_reg;
                    rdata[15:8] = oeb_reg;
                end
                2'd2: begin
                    rdata[2:0] = db;
                    rdata[6:4] = pend_reg;
                end
                default: rdata = '0;
            endcase
        end
    end

    always_comb begin
        evt_clr = 3'b000;
        if (wr_en && reg_off == 2'd3 && wbs_sel_i[0])
            evt_clr = wbs_dat_i[6:4];
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            sync1_reg   <= 3'b000;
            sync2_reg   <= 3'b000;
            pend_reg    <= 3'b000;
            led_reg     <= 8'h00;
            mode_reg    <= 1'b0;
            irq_en_reg  <= 3'b000;
            oeb_reg     <= 8'h00;
            ack_reg     <= 1'b0;
            dat_reg     <= '0;
            led_out_reg <= 8'h00;
            irq_reg     <= 1'b0;
        end else begin
            sync1_reg <= btn_i;
            sync2_reg <= sync1_reg;

            if (wr_en && reg_off == 2'd0 && wbs_sel_i[0])
                led_reg <= wbs_dat_i[7:0];
            if (wr_en && reg_off == 2'd1) begin
                if (wbs_sel_i[0]) begin
                    mode_reg   <= wbs_dat_i[0];
                    irq_en_reg <= wbs_dat_i[6:4];
                end
                if (wbs_sel_i[1])
                    oeb_reg <= wbs_dat_i[15:8];
            end

            // A new rising edge wins over a simultaneous W1C clear.
            pend_reg <= (pend_reg & ~evt_clr) | db_rise;

            ack_reg <= wb_req;
            dat_reg <= wb_req ? rdata : '0;

            led_out_reg <= mode_reg ? {{3{db[2]}}, {3{db[1]}}, {2{db[0]}}} : led_reg;
            irq_reg     <= |(pend_reg & irq_en_reg);
        end
    end

    assign wbs_ack_o = ack_reg;
    assign wbs_dat_o = dat_reg;
    assign led_o     = led_out_reg;
    assign led_oeb_o = oeb_reg;
    assign irq_o     = irq_reg;

    assign unused_bits = ^{wbs_sel_i[3:2], wbs_dat_i[31:16], wbs_adr_i[1:0]};

endmodule

// File: tb/tb_button_led_wb.sv
// Randomized bench for button_led_wb: a cycle-level behavioural model is
// compared against every output each cycle, plus directed literal checks.
module tb_button_led_wb;

    localparam int          DB   = 8;
    localparam logic [31:0] BASE = 32'h3000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        stb, cyc, we;
    logic [3:0]  sel;
    logic [31:0] adr, wdat;
    logic        ack;
    logic [31:0] dat_o;
    logic [2:0]  btn;
    logic [7:0]  led, oeb;
    logic        irq;

    int vectors     = 0;
    int miscompares = 0;
    bit chk_en      = 1'b0;

    button_led_wb #(.BASE_ADDR(BASE), .DB_CYCLES(DB)) dut (
        .wb_clk_i  (clk),
        .wb_rst_i  (rst),
        .wbs_stb_i (stb),
        .wbs_cyc_i (cyc),
        .wbs_we_i  (we),
        .wbs_sel_i (sel),
        .wbs_adr_i (adr),
        .wbs_dat_i (wdat),
        .wbs_ack_o (ack),
        .wbs_dat_o (dat_o),
        .btn_i     (btn),
        .led_o     (led),
        .led_oeb_o (oeb),
        .irq_o     (irq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Behavioural model: m_run counts consecutive clocks the synced button
    // disagrees with the debounced level; DB such clocks toggle the level.
    logic [2:0]  m_h1, m_h2, m_db, m_pend, m_irqen;
    int          m_run [3];
    logic [7:0]  m_led, m_oeb, m_ledo;
    logic        m_mode, m_ack, m_irq;
    logic [31:0] m_dat;

    always @(posedge clk or posedge rst) begin : model
        logic [2:0]  ndb, clr, rise;
        int          nrun [3];
        logic [31:0] rd;
        logic        req, hit;
        int          off;
        logic [7:0]  pat;
        if (rst) begin
            m_h1 <= '0; m_h2 <= '0; m_db <= '0; m_pend <= '0; m_irqen <= '0;
            m_led <= '0; m_oeb <= '0; m_ledo <= '0; m_mode <= 1'b0;
            m_ack <= 1'b0; m_irq <= 1'b0; m_dat <= '0;
            for (int i = 0; i < 3; i++) m_run[i] <= 0;
        end else begin
            ndb = m_db;
            for (int i = 0; i < 3; i++) begin
                nrun[i] = 0;
                if (m_h2[i] != m_db[i]) begin
                    nrun[i] = m_run[i] + 1;
                    if (nrun[i] == DB) begin
                        ndb[i]  = ~m_db[i];
                        nrun[i] = 0;
                    end
                end
            end
            rise = ndb & ~m_db;

            req = stb && cyc && !m_ack;
            hit = (adr >> 4) == (BASE >> 4);
            off = int'(adr[3:2]);
            rd  = 0;
            if (hit) begin
                if (off == 0) rd = 32'(m_led);
                if (off == 1) rd = 32'(m_mode) + (32'(m_irqen) << 4) + (32'(m_oeb) << 8);
                if (off == 2) rd = 32'(m_db) + (32'(m_pend) << 4);
            end
            clr = 3'b000;
            if (req && we && hit) begin
                if (off == 0 && sel[0]) m_led <= wdat[7:0];
                if (off == 1 && sel[0]) begin
                    m_mode  <= wdat[0];
                    m_irqen <= wdat[6:4];
                end
                if (off == 1 && sel[1]) m_oeb <= wdat[15:8];
                if (off == 3 && sel[0]) clr = wdat[6:4];
            end
            for (int k = 0; k < 8; k++) pat[k] = m_db[(k + 1) / 3];

            m_pend <= (m_pend & ~clr) | rise;
            m_ack  <= req;
            m_dat  <= req ? rd : 32'd0;
            m_ledo <= m_mode ? pat : m_led;
            m_irq  <= (m_pend & m_irqen) != 0;
            m_h1   <= btn;
            m_h2   <= m_h1;
            m_db   <= ndb;
            for (int i = 0; i < 3; i++) m_run[i] <= nrun[i];
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("ack",     32'(ack),   32'(m_ack));
            chk("dat_o",   dat_o,      m_dat);
            chk("led_o",   32'(led),   32'(m_ledo));
            chk("led_oeb", 32'(oeb),   32'(m_oeb));
            chk("irq_o",   32'(irq),   32'(m_irq));
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Called at a negedge; returns at the negedge of the ack cycle.
    task automatic wb_xfer(input logic w, input logic [31:0] a, input logic [31:0] d,
                           input logic [3:0] s, output logic [31:0] r);
        bit got = 1'b0;
        r = '0;
        stb = 1'b1; cyc = 1'b1; we = w; adr = a; wdat = d; sel = s;
        for (int k = 0; k < 4 && !got; k++) begin
            @(negedge clk);
            if (ack) begin
                got = 1'b1;
                r   = dat_o;
            end
        end
        stb = 1'b0; cyc = 1'b0; we = 1'b0;
        chk("ack_seen", 32'(got), 32'd1);
    endtask

    initial begin : stim
        logic [31:0] r, a;
        int          acks, o;
        bit          found;
        stb = 1'b0; cyc = 1'b0; we = 1'b0; sel = '0; adr = '0; wdat = '0; btn = '0;

        #3 rst = 1'b1;
        #1;
        chk("rst_led", 32'(led), 32'd0);
        chk("rst_oeb", 32'(oeb), 32'd0);
        chk("rst_irq", 32'(irq), 32'd0);
        chk("rst_ack", 32'(ack), 32'd0);
        @(negedge clk);
        #2 rst = 1'b0;
        chk_en = 1'b1;
        @(negedge clk);

        // LED write through lane 0, readback, and a write with no lanes
        wb_xfer(1'b1, BASE, 32'hDEAD_BEA5, 4'b0001, r);
        @(negedge clk);
        chk("led_after_write", 32'(led), 32'h0000_00A5);
        wb_xfer(1'b0, BASE, 32'h0, 4'hF, r);
        chk("led_readback", r, 32'h0000_00A5);
        wb_xfer(1'b1, BASE, 32'h0000_003C, 4'b0000, r);
        wb_xfer(1'b0, BASE, 32'h0, 4'hF, r);
        chk("led_sel_none", r, 32'h0000_00A5);

        // Short glitch on button 0 must be filtered
        btn = 3'b001;
        idle(DB - 2);
        btn = 3'b000;
        idle(DB + 4);
        wb_xfer(1'b0, BASE + 32'h8, 32'h0, 4'hF, r);
        chk("glitch_status", r, 32'h0);
        chk("glitch_led", 32'(led), 32'hA5);

        // Mirror mode with all buttons held
        wb_xfer(1'b1, BASE + 32'h4, 32'h0000_0001, 4'b0001, r);
        btn = 3'b111;
        idle(DB + 6);
        chk("mode1_led", 32'(led), 32'hFF);
        wb_xfer(1'b0, BASE + 32'h8, 32'h0, 4'hF, r);
        chk("mode1_status", r, 32'h77);

        // Interrupt flow
        btn = 3'b000;
        idle(DB + 6);
        wb_xfer(1'b1, BASE + 32'hC, 32'h70, 4'b0001, r);
        wb_xfer(1'b1, BASE + 32'h4, 32'h0000_1210, 4'b0011, r);
        idle(1);
        chk("irq_idle", 32'(irq), 32'd0);
        chk("oeb_value", 32'(oeb), 32'h12);
        btn = 3'b001;
        idle(DB + 6);
        chk("irq_press", 32'(irq), 32'd1);
        btn = 3'b000;
        idle(DB + 6);
        chk("irq_sticky", 32'(irq), 32'd1);
        wb_xfer(1'b1, BASE + 32'hC, 32'h10, 4'b0001, r);
        @(negedge clk);
        chk("irq_cleared", 32'(irq), 32'd0);

        // Clear issued on the very edge where db[0] rises
        btn = 3'b001;
        found = 1'b0;
        for (int k = 0; k < 40 && !found; k++) begin
            if (m_h2[0] != m_db[0] && m_run[0] == DB - 1) found = 1'b1;
            else @(negedge clk);
        end
        chk("edge_found", 32'(found), 32'd1);
        wb_xfer(1'b1, BASE + 32'hC, 32'h10, 4'b0001, r);
        wb_xfer(1'b0, BASE + 32'h8, 32'h0, 4'hF, r);
        chk("set_beats_clear", r, 32'h11);
        chk("irq_after_race", 32'(irq), 32'd1);

        // Address miss just past the register block
        wb_xfer(1'b1, BASE + 32'h10, 32'hFFFF_FFFF, 4'hF, r);
        chk("miss_wdat", r, 32'h0);
        wb_xfer(1'b0, BASE + 32'h10, 32'h0, 4'hF, r);
        chk("miss_rdat", r, 32'h0);
        wb_xfer(1'b0, BASE, 32'h0, 4'hF, r);
        chk("miss_led_kept", r, 32'hA5);
        wb_xfer(1'b0, BASE + 32'h4, 32'h0, 4'hF, r);
        chk("miss_ctrl_kept", r, 32'h1210);

        // Strobe held continuously: acks on alternate cycles
        stb = 1'b1; cyc = 1'b1; we = 1'b0; adr = BASE;
        acks = 0;
        repeat (6) begin
            @(negedge clk);
            if (ack) acks++;
        end
        stb = 1'b0; cyc = 1'b0;
        chk("b2b_acks", 32'(acks), 32'd3);
        idle(1);

        // Reset between strobe and ack
        stb = 1'b1; cyc = 1'b1; we = 1'b1; adr = BASE; wdat = 32'h55; sel = 4'b0001;
        #2 rst = 1'b1;
        #1;
        chk("midrst_led", 32'(led), 32'd0);
        chk("midrst_oeb", 32'(oeb), 32'd0);
        chk("midrst_irq", 32'(irq), 32'd0);
        chk("midrst_ack", 32'(ack), 32'd0);
        chk("midrst_dat", dat_o, 32'd0);
        @(negedge clk);
        stb = 1'b0; cyc = 1'b0; we = 1'b0;
        #2 rst = 1'b0;
        acks = 0;
        repeat (3) begin
            @(negedge clk);
            if (ack) acks++;
        end
        chk("midrst_no_ack", 32'(acks), 32'd0);
        wb_xfer(1'b0, BASE, 32'h0, 4'hF, r);
        chk("midrst_led_reg", r, 32'h0);

        // Random traffic against the model
        for (int t = 0; t < 300; t++) begin
            if ($urandom_range(0, 3) == 0) btn = 3'($urandom);
            case ($urandom_range(0, 2))
                0: idle(int'($urandom_range(1, DB + 3)));
                1: begin
                    o = int'($urandom_range(0, 4));
                    a = (o == 4) ? BASE + 32'h10 : BASE + 32'(o * 4);
                    a = a + 32'($urandom_range(0, 3));
                    wb_xfer(1'($urandom_range(0, 1)), a, $urandom, 4'($urandom), r);
                end
                default: begin
                    stb = 1'b1; cyc = 1'b0;
                    @(negedge clk);
                    stb = 1'b0;
                end
            endcase
        end
        idle(2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
